crc32_slice_pipe: RTL and testbench
===================================

Name: crc32_slice_pipe

Overview:
- Parametrised slicing-by-N CRC engine. Consumes BEAT_BYTES message bytes per clock through elaboration-generated lookup tables; default is reflected CRC-32C.
- Successor to the fixed single-table 256x32 LUT block. Adds an arbitrary polynomial, variable beat width, partial-beat tail handling, message length counting and valid/ready handshakes on both sides.
- Sits between the packet byte stream and the checksum compare/insert logic.

Parameters:
- BEAT_BYTES, 8: bytes per input beat. Legal values are 1, 2, 4, 8.
- POLY, 32'h82F63B78: reflected (LSB-first) generator polynomial.
- INIT, 32'hFFFFFFFF: CRC register value at message start.
- XOROUT, 32'hFFFFFFFF: value XORed into the final CRC.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid and in_ready are both high
- in_data  in  8*BEAT_BYTES  message bytes; byte 0 = in_data[7:0] is first in the stream
- in_last  in  1  final beat of the message
- in_nbytes  in  4  valid bytes in the last beat, bytes 0..in_nbytes-1. Sampled only with in_last. Value 0 or >BEAT_BYTES means a full beat.
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid and out_ready are both high
- out_crc  out  32  final CRC (crc ^ XOROUT)
- out_bytes  out  32  message length in bytes, modulo 2^32

Behaviour:
- Clock/reset: single clock, clk. Reset is synchronous, active-low, on rstn.
- Reset values: in_ready=0, out_valid=0, out_crc=0, out_bytes=0, state=RUN, crc=INIT, byte count=0. in_ready goes to 1 on the first cycle after rstn is released.
- Tables:
  - T0[i] is the standard reflected byte table for POLY.
  - Tk[i] = (T(k-1)[i] >> 8) ^ T0[T(k-1)[i] & 8'hFF], for k = 1..BEAT_BYTES-1.
  - Built at elaboration by a constant function. No runtime memory initialisation.
  - Reads are combinational.
- Beat update (full beat, RUN state):
  - Byte j uses table T(BEAT_BYTES-1-j).
  - Index for j<4: byte_j ^ crc[8j+7:8j]. Index for j>=4: byte_j.
  - crc_next = XOR of all lookups ^ (crc >> 8*BEAT_BYTES). The shift term is 0 when BEAT_BYTES >= 4.
- FSM states: RUN, TAIL, OUT.
- RUN:
  - in_ready=1.
  - Non-last beat accepted: crc <= crc_next; count += BEAT_BYTES.
  - Full last beat accepted: latch crc_next ^ XOROUT into out_crc and the final count into out_bytes; go to OUT.
  - Partial last beat accepted: latch in_data and n=in_nbytes into the tail register; crc unchanged; go to TAIL.
- TAIL:
  - in_ready=0.
  - One byte per cycle, lowest first: crc <= (crc >> 8) ^ T0[crc[7:0] ^ byte]; count += 1.
  - After the n-th byte, latch out_crc/out_bytes; go to OUT.
- OUT:
  - out_valid=1 and in_ready=0. out_crc and out_bytes are held stable until the handshake.
  - On out_ready: out_valid <= 0, crc <= INIT, count <= 0; go to RUN.
- Latency:
  - Full last beat accepted in cycle t: out_valid rises at t+1.
  - Partial last beat with n bytes: out_valid rises at t+n+1.
  - Minimum gap between messages is one bubble cycle (the OUT state).
- Zero-length messages cannot be expressed. Every message has at least 1 byte.
- in_data, in_last and in_nbytes are ignored when in_valid=0 or in_ready=0.
- Reset asserted in any state, including mid-message or while holding a result: abandon all work and return to the reset values on the next edge. No stale output is ever presented.

Test Plan:
- ASCII "123456789", BEAT_BYTES=8: beat0 "12345678", beat1 "9" with in_last=1, in_nbytes=1 -> out_crc=32'hE3069283, out_bytes=9. out_valid rises 2 cycles after beat1 is accepted.
- Single byte 8'h00, in_last=1, in_nbytes=1 -> out_crc=32'h527D5351, out_bytes=1.
- 32 bytes of 8'h00 as 4 full beats -> 32'h8A9136AA. 32 bytes of 8'hFF -> 32'h62A8AB43. Bytes 0x00..0x1F ascending -> 32'h46DD794E. Each result is valid 1 cycle after the last beat.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready stays 0 and out_crc/out_bytes stay stable. A back-to-back second "123456789" message then yields 32'hE3069283 again, confirming crc/count reinitialise to INIT/0.
- Deassert rstn in the middle of the tail of the "123456789" message -> next cycle out_valid=0, in_ready=0. After release, resending the message yields 32'hE3069283.
- Rerun the "123456789" vector at BEAT_BYTES=1, 2 and 4 -> 32'hE3069283 in every configuration. Random messages at each width match a bitwise reference model.

Source files
------------

// File: rtl/crc32_slice_pipe.sv
// crc32_slice_pipe
// ----------------
// A slicing-by-N CRC engine. It consumes BEAT_BYTES message bytes per clock
// through lookup tables that are built at elaboration time. The default
// configuration computes reflected CRC-32C (Castagnoli). A partial final beat
// is drained one byte per cycle through the base table. The engine also
// counts the message length. Both sides use a valid/ready handshake.
//
// Parameters
//   BEAT_BYTES : bytes per input beat (1, 2, 4 or 8)
//   POLY       : reflected (LSB-first) generator polynomial
//   INIT       : CRC register value at message start
//   XOROUT     : value XORed into the final CRC
//
// Ports
//   clk        : clock
//   rstn       : synchronous active-low reset
//   in_valid   : input beat valid
//   in_ready   : input beat accepted when in_valid and in_ready are both high
//   in_data    : message bytes, byte 0 = in_data[7:0] is first in the stream
//   in_last    : final beat of the message
//   in_nbytes  : valid bytes in the last beat (0 or >BEAT_BYTES = full beat)
//   out_valid  : result valid
//   out_ready  : result consumed when out_valid and out_ready are both high
//   out_crc    : final CRC (crc ^ XOROUT)
//   out_bytes  : message length in bytes, modulo 2^32

module crc32_slice_pipe #(
   parameter int unsigned BEAT_BYTES = 8,
   parameter logic [31:0] POLY       = 32'h82F63B78,
   parameter logic [31:0] INIT       = 32'hFFFFFFFF,
   parameter logic [31:0] XOROUT     = 32'hFFFFFFFF
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [8*BEAT_BYTES-1:0] in_data,
   input  logic                    in_last,
   input  logic [3:0]              in_nbytes,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_crc,
   output logic [31:0]             out_bytes
);

   localparam int W = 8 * BEAT_BYTES;

   typedef enum logic [1:0] {
      RUN,
      TAIL,
      OUT
   } state_t;

   // Standard reflected byte-table entry: eight LSB-first polynomial steps.
   function automatic logic [31:0] t0_entry(input logic [7:0] idx);
      logic [31:0] c;
      c = {24'd0, idx};
      for (int b = 0; b < 8; b++) begin
         c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
      end
      return c;
   endfunction

   // Table k advances a byte by k extra zero bytes. This lets the bytes of
   // one beat be folded independently and then XORed together.
   function automatic logic [31:0] table_entry(input int k, input int i);
      logic [31:0] v;
      v = t0_entry(8'(i));
      for (int m = 1; m <= k; m++) begin
         v = (v >> 8) ^ t0_entry(v[7:0]);
      end
      return v;
   endfunction

   logic [31:0] tbl [BEAT_BYTES][256];

   for (genvar k = 0; k < BEAT_BYTES; k++) begin : g_tbl
      for (genvar i = 0; i < 256; i++) begin : g_ent
         assign tbl[k][i] = table_entry(k, i);
      end
   end

   state_t      state, state_d;
   logic [31:0] crc, crc_d;
   logic [31:0] count, count_d;
   logic [W-1:0] tail_data, tail_data_d;
   logic [3:0]  tail_left, tail_left_d;
   logic [31:0] out_crc_d, out_bytes_d;
   logic [31:0] beat_crc, tail_crc;
   logic        partial;

   // Only the four low message bytes overlap the 32-bit CRC register. The
   // higher bytes index their tables with the raw data byte alone.
   logic [7:0] crc_byte [BEAT_BYTES];

   for (genvar j = 0; j < BEAT_BYTES; j++) begin : g_cb
      if (j < 4) begin : g_ov
         assign crc_byte[j] = crc[8*j +: 8];
      end else begin : g_zero
         assign crc_byte[j] = 8'd0;
      end
   end

   // Full-beat update. Byte j is followed by BEAT_BYTES-1-j later bytes, so it
   // uses that table. For beats narrower than the register, the untouched
   // upper CRC bits shift down. Those bits are zero for beats of 4 or 8 bytes.
   always_comb begin
      beat_crc = (BEAT_BYTES >= 4) ? 32'd0 : (crc >> (8 * BEAT_BYTES));
      for (int j = 0; j < BEAT_BYTES; j++) begin
         beat_crc = beat_crc ^ tbl[BEAT_BYTES-1-j][in_data[8*j +: 8] ^ crc_byte[j]];
      end
   end

   assign tail_crc = (crc >> 8) ^ tbl[0][crc[7:0] ^ tail_data[7:0]];
   assign partial  = (in_nbytes != 4'd0) && (32'(in_nbytes) < BEAT_BYTES);

   // Next-state and datapath decisions. in_ready and out_valid are
   // registered from the next state. This keeps them low during reset and
   // makes in_ready rise only on the cycle after reset is released.
   always_comb begin
      state_d     = state;
      crc_d       = crc;
      count_d     = count;
      tail_data_d = tail_data;
      tail_left_d = tail_left;
      out_crc_d   = out_crc;
      out_bytes_d = out_bytes;
      case (state)
         RUN: begin
            if (in_valid && in_ready) begin
               if (!in_last) begin
                  crc_d   = beat_crc;
                  count_d = count + 32'(BEAT_BYTES);
               end else if (partial) begin
                  tail_data_d = in_data;
                  tail_left_d = in_nbytes;
                  state_d     = TAIL;
               end else begin
                  out_crc_d   = beat_crc ^ XOROUT;
                  out_bytes_d = count + 32'(BEAT_BYTES);
                  state_d     = OUT;
               end
            end
         end
         TAIL: begin
            crc_d       = tail_crc;
            count_d     = count + 32'd1;
            tail_data_d = tail_data >> 8;
            tail_left_d = tail_left - 4'd1;
            if (tail_left == 4'd1) begin
               out_crc_d   = tail_crc ^ XOROUT;
               out_bytes_d = count + 32'd1;
               state_d     = OUT;
            end
         end
         OUT: begin
            if (out_valid && out_ready) begin
               crc_d   = INIT;
               count_d = 32'd0;
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // State and datapath registers. Reset discards any message in progress
   // and any pending result.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= RUN;
         crc       <= INIT;
         count     <= 32'd0;
         tail_data <= '0;
         tail_left <= 4'd0;
         out_crc   <= 32'd0;
         out_bytes <= 32'd0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_d;
         crc       <= crc_d;
         count     <= count_d;
         tail_data <= tail_data_d;
         tail_left <= tail_left_d;
         out_crc   <= out_crc_d;
         out_bytes <= out_bytes_d;
         in_ready  <= (state_d == RUN);
         out_valid <= (state_d == OUT);
      end
   end

endmodule

// File: tb/tb_crc32_slice_pipe.sv
// tb_crc32_slice_pipe
// -------------------
// Testbench for crc32_slice_pipe. It holds four instances, one per beat
// width (1, 2, 4 and 8 bytes). One instance is exercised at a time. The
// driver pushes the expected CRC, length and output latency into a queue.
// A negedge monitor pops the queue and compares on every output handshake.

module tb_crc32_slice_pipe;

   localparam logic [31:0] CHECK_123 = 32'hE3069283;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic [3:0]  in_valid_v;
   logic [3:0]  in_last_v;
   logic [3:0]  out_ready_v;
   logic [63:0] in_data_v [4];
   logic [3:0]  in_nbytes_v [4];
   wire  [3:0]  in_ready_v;
   wire  [3:0]  out_valid_v;
   wire  [31:0] out_crc_v [4];
   wire  [31:0] out_bytes_v [4];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int BB = 1 << g;
      crc32_slice_pipe #(.BEAT_BYTES(BB)) dut (
         .clk       (clk),
         .rstn      (rstn),
         .in_valid  (in_valid_v[g]),
         .in_ready  (in_ready_v[g]),
         .in_data   (in_data_v[g][8*BB-1:0]),
         .in_last   (in_last_v[g]),
         .in_nbytes (in_nbytes_v[g]),
         .out_valid (out_valid_v[g]),
         .out_ready (out_ready_v[g]),
         .out_crc   (out_crc_v[g]),
         .out_bytes (out_bytes_v[g])
      );
   end

   typedef struct {
      logic [31:0] crc;
      logic [31:0] len;
      int          lat;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] msg[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         last_accept_cyc [4];
   logic [3:0] prev_valid = 4'd0;

   // Free-running cycle counter used for latency measurement
   always @(posedge clk) cyc <= cyc + 1;

   // Common comparison: counts every check and reports mismatches
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Bit-serial reference CRC-32C over the current message
   function automatic logic [31:0] crcModel();
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (msg[i]) begin
         c = c ^ {24'd0, msg[i]};
         for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'h82F63B78) : (c >> 1);
         end
      end
      return c ^ 32'hFFFFFFFF;
   endfunction

   task automatic loadAscii();
      msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
   endtask

   // Monitor: checks the output latency when out_valid rises and the
   // result on each handshake
   always @(negedge clk) begin
      for (int g = 0; g < 4; g++) begin
         if (out_valid_v[g] && !prev_valid[g]) begin
            if (exp_q.size() == 0)
               checkOutput($sformatf("spurious out_valid w%0d", 1 << g), 32'(out_valid_v[g]), 32'd0);
            else
               checkOutput($sformatf("latency w%0d", 1 << g), 32'(cyc - last_accept_cyc[g]), 32'(exp_q[0].lat));
         end
         if (out_valid_v[g] && out_ready_v[g] && exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput($sformatf("out_crc w%0d", 1 << g), out_crc_v[g], e.crc);
            checkOutput($sformatf("out_bytes w%0d", 1 << g), out_bytes_v[g], e.len);
         end
         prev_valid[g] = out_valid_v[g];
      end
   end

   // Holds the current beat until it is accepted (bounded wait)
   task automatic waitAccept(input int g);
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!in_ready_v[g] && t < 200);
      checkOutput($sformatf("in_ready accept w%0d", 1 << g), 32'(in_ready_v[g]), 32'd1);
      last_accept_cyc[g] = cyc;
      @(posedge clk);
      #1;
   endtask

   // Sends msg to the instance of width 1<<g. Unused lanes carry random
   // bytes. A full last beat is flagged with in_nbytes of 0, 15 or the beat
   // width.
   task automatic applyStimulus(input int g, input logic [31:0] exp_crc, input bit push_exp);
      int bb;
      int len;
      int nbeats;
      int rem;
      exp_t e;
      bb     = 1 << g;
      len    = msg.size();
      nbeats = (len + bb - 1) / bb;
      rem    = len % bb;
      if (push_exp) begin
         e.crc = exp_crc;
         e.len = 32'(len);
         e.lat = (rem == 0) ? 1 : rem + 1;
         exp_q.push_back(e);
      end
      for (int b = 0; b < nbeats; b++) begin
         logic [63:0] d;
         int nb;
         d  = {$urandom, $urandom};
         nb = len - b * bb;
         for (int k = 0; k < bb; k++) begin
            if (b * bb + k < len) d[8*k +: 8] = msg[b * bb + k];
         end
         in_data_v[g] = d;
         in_last_v[g] = (b == nbeats - 1);
         if (b == nbeats - 1) begin
            if (nb >= bb)
               in_nbytes_v[g] = ((len & 8) != 0) ? 4'd0 : (((len & 4) != 0) ? 4'd15 : 4'(bb));
            else
               in_nbytes_v[g] = 4'(nb);
         end else begin
            in_nbytes_v[g] = 4'($urandom_range(1, 7));
         end
         in_valid_v[g] = 1'b1;
         waitAccept(g);
      end
      in_valid_v[g]  = 1'b0;
      in_last_v[g]   = 1'($urandom);
      in_data_v[g]   = {$urandom, $urandom};
   endtask

   // Waits, within a bound, until every expected result has been consumed
   task automatic drainQueue();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      checkOutput("drain pending results", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // Watchdog
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t;
      rstn        = 1'b0;
      in_valid_v  = 4'd0;
      in_last_v   = 4'd0;
      out_ready_v = 4'hF;
      for (int g = 0; g < 4; g++) begin
         in_data_v[g]       = 64'd0;
         in_nbytes_v[g]     = 4'd0;
         last_accept_cyc[g] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
         checkOutput($sformatf("reset in_ready w%0d", 1 << g), 32'(in_ready_v[g]), 32'd0);
         checkOutput($sformatf("reset out_valid w%0d", 1 << g), 32'(out_valid_v[g]), 32'd0);
         checkOutput($sformatf("reset out_crc w%0d", 1 << g), out_crc_v[g], 32'd0);
         checkOutput($sformatf("reset out_bytes w%0d", 1 << g), out_bytes_v[g], 32'd0);
      end
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // "123456789" at every width
      for (int g = 0; g < 4; g++) begin
         loadAscii();
         applyStimulus(g, CHECK_123, 1'b1);
         drainQueue();
      end

      // Single zero byte: partial tail at width 8, full beat at width 1
      msg = '{8'h00};
      applyStimulus(3, 32'h527D5351, 1'b1);
      drainQueue();
      applyStimulus(0, 32'h527D5351, 1'b1);
      drainQueue();

      // 32-byte directed vectors as four full beats
      msg.delete();
      for (int i = 0; i < 32; i++) msg.push_back(8'h00);
      applyStimulus(3, 32'h8A9136AA, 1'b1);
      drainQueue();
      msg.delete();
      for (int i = 0; i < 32; i++) msg.push_back(8'hFF);
      applyStimulus(3, 32'h62A8AB43, 1'b1);
      drainQueue();
      msg.delete();
      for (int i = 0; i < 32; i++) msg.push_back(8'(i));
      applyStimulus(3, 32'h46DD794E, 1'b1);
      drainQueue();

      // Back-pressure on the result while the source keeps offering beats
      loadAscii();
      out_ready_v[3] = 1'b0;
      applyStimulus(3, CHECK_123, 1'b1);
      t = 0;
      while (!out_valid_v[3] && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      checkOutput("stall out_valid", 32'(out_valid_v[3]), 32'd1);
      for (int i = 0; i < 5; i++) begin
         in_valid_v[3]  = 1'b1;
         in_last_v[3]   = 1'b1;
         in_nbytes_v[3] = 4'd0;
         in_data_v[3]   = {$urandom, $urandom};
         @(negedge clk);
         checkOutput("stall in_ready", 32'(in_ready_v[3]), 32'd0);
         checkOutput("stall out_crc", out_crc_v[3], CHECK_123);
         checkOutput("stall out_bytes", out_bytes_v[3], 32'd9);
         @(posedge clk);
         #1;
      end
      in_valid_v[3]  = 1'b0;
      out_ready_v[3] = 1'b1;
      applyStimulus(3, CHECK_123, 1'b1);
      drainQueue();

      // Reset while the tail byte is pending
      loadAscii();
      applyStimulus(3, 32'd0, 1'b0);
      rstn = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("mid-tail reset out_valid", 32'(out_valid_v[3]), 32'd0);
      checkOutput("mid-tail reset in_ready", 32'(in_ready_v[3]), 32'd0);
      checkOutput("mid-tail reset out_crc", out_crc_v[3], 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      applyStimulus(3, CHECK_123, 1'b1);
      drainQueue();

      // Random messages at every width against the bit-serial model
      for (int g = 0; g < 4; g++) begin
         for (int m = 0; m < 4; m++) begin
            int len;
            len = $urandom_range(1, 24);
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            applyStimulus(g, crcModel(), 1'b1);
            drainQueue();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
